midi_encode: RTL

Builds 3-byte MIDI Note On/Off messages from parallel note events and serializes them onto a MIDI OUT line at 31250 baud, 8N1. It is the transmit-side counterpart of the MIDI note decoder. It takes one event per valid/ready handshake and contains its own UART serializer. Typical use is echoing or synthesizing notes back out to an external synth or DAW.

---
 rtl/midi_encode.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/midi_encode.sv
// midi_encode
// Builds 3-byte MIDI Note On/Off messages from parallel note events and
// shifts them out as 8N1 serial at BAUD_RATE on an idle-high MIDI OUT line.
//
// Parameters
//   INPUT_CLOCK_FREQ  : system clock in Hz
//   BAUD_RATE         : serial rate in bit/s (BAUD_PERIOD = freq / rate)
//   RUNNING_STATUS_EN : 1 = omit the status byte when it repeats the last one
//
// Ports
//   clk_in        : system clock, rising edge
//   rst_in        : asynchronous active-low reset
//   note_valid_in : event valid
//   ready_out     : event can be accepted this cycle
//   status_in     : 1 = Note On (0x9n), 0 = Note Off (0x8n)
//   channel_in    : MIDI channel n
//   note_in       : note number (bit 7 dropped)
//   velocity_in   : velocity (bit 7 dropped)
//   tx_wire_out   : registered serial line, idle high
//   busy_out      : high from acceptance until the last stop bit ends
//   msg_done_out  : one-cycle pulse after the last stop bit of a message
module midi_encode #(
  parameter int INPUT_CLOCK_FREQ  = 100_000_000,
  parameter int BAUD_RATE         = 31250,
  parameter bit RUNNING_STATUS_EN = 1'b0
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       note_valid_in,
  output logic       ready_out,
  input  logic       status_in,
  input  logic [3:0] channel_in,
  input  logic [7:0] note_in,
  input  logic [7:0] velocity_in,
  output logic       tx_wire_out,
  output logic       busy_out,
  output logic       msg_done_out
);

  localparam int BAUD_PERIOD = INPUT_CLOCK_FREQ / BAUD_RATE;
  localparam int CNT_W       = (BAUD_PERIOD > 1) ? $clog2(BAUD_PERIOD) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_PERIOD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [CNT_W-1:0] r_baudCnt;
  logic [CNT_W-1:0] w_nextBaud;
  logic [2:0]       r_bitIdx;
  logic [2:0]       w_nextBit;
  logic [1:0]       r_byteIdx;
  logic [1:0]       w_nextByte;
  logic [23:0]      r_msg;
  logic [7:0]       r_lastStatus;
  logic             r_tx;

  logic             w_accept;
  logic             w_skip;
  logic             w_baudLast;
  logic [7:0]       w_status;
  logic [7:0]       w_data1;
  logic [7:0]       w_data2;
  logic [7:0]       w_txByte;
  logic             w_txNext;

  // Message bytes assembled straight from the event inputs; the data bytes
  // have bit 7 cleared so they can never be mistaken for a status byte.
  assign w_status = {(status_in ? 4'h9 : 4'h8), channel_in};
  assign w_data1  = note_in & 8'h7F;
  assign w_data2  = velocity_in & 8'h7F;

  // Last-status resets to 0x00, which no real status byte can equal, so the
  // first event after reset always carries its status byte.
  assign w_skip     = RUNNING_STATUS_EN && (w_status == r_lastStatus);
  assign w_baudLast = (r_baudCnt == BAUD_LAST);

  // DONE doubles as an accepting state so a held valid starts the next
  // message without an extra idle cycle.
  assign ready_out    = (r_state == S_IDLE) || (r_state == S_DONE);
  assign busy_out     = !ready_out;
  assign msg_done_out = (r_state == S_DONE);
  assign tx_wire_out  = r_tx;

  // Next-state logic: each line state holds for one baud period, bytes run
  // start -> 8 data bits -> stop, and the stop of the final byte leads to DONE.
  // A skipped status byte simply starts the byte index at 1.
  always_comb begin
    w_nextState = r_state;
    w_nextBaud  = r_baudCnt;
    w_nextBit   = r_bitIdx;
    w_nextByte  = r_byteIdx;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        w_nextState = S_IDLE;
        if (note_valid_in) begin
          w_accept    = 1'b1;
          w_nextState = S_START;
          w_nextBaud  = '0;
          w_nextBit   = 3'd0;
          w_nextByte  = w_skip ? 2'd1 : 2'd0;
        end
      end
      S_START: begin
        if (w_baudLast) begin
          w_nextBaud  = '0;
          w_nextBit   = 3'd0;
          w_nextState = S_DATA;
        end else begin
          w_nextBaud = r_baudCnt + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (w_baudLast) begin
          w_nextBaud = '0;
          if (r_bitIdx == 3'd7) begin
            w_nextState = S_STOP;
          end else begin
            w_nextBit = r_bitIdx + 3'd1;
          end
        end else begin
          w_nextBaud = r_baudCnt + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (w_baudLast) begin
          w_nextBaud = '0;
          if (r_byteIdx == 2'd2) begin
            w_nextState = S_DONE;
          end else begin
            w_nextByte  = r_byteIdx + 2'd1;
            w_nextState = S_START;
          end
        end else begin
          w_nextBaud = r_baudCnt + CNT_W'(1);
        end
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  // The line level is computed for the state being entered and registered,
  // so the start bit appears on the first cycle after acceptance and the
  // output never has a combinational path from the inputs.
  always_comb begin
    w_txByte = r_msg[7:0];
    case (w_nextByte)
      2'd0:    w_txByte = r_msg[23:16];
      2'd1:    w_txByte = r_msg[15:8];
      default: w_txByte = r_msg[7:0];
    endcase
    w_txNext = 1'b1;
    case (w_nextState)
      S_START: w_txNext = 1'b0;
      S_DATA:  w_txNext = w_txByte[w_nextBit];
      default: w_txNext = 1'b1;
    endcase
  end

  // State, counters and line register; reset aborts any byte in flight.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state   <= S_IDLE;
      r_baudCnt <= '0;
      r_bitIdx  <= 3'd0;
      r_byteIdx <= 2'd0;
      r_tx      <= 1'b1;
    end else begin
      r_state   <= w_nextState;
      r_baudCnt <= w_nextBaud;
      r_bitIdx  <= w_nextBit;
      r_byteIdx <= w_nextByte;
      r_tx      <= w_txNext;
    end
  end

  // Event capture: the message and running-status memory only change on
  // acceptance, so the inputs are free to move during transmission.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_msg        <= 24'h0;
      r_lastStatus <= 8'h00;
    end else if (w_accept) begin
      r_msg        <= {w_status, w_data1, w_data2};
      r_lastStatus <= w_status;
    end
  end

endmodule
